// File: rtl/pps_pfd_ctrl_pkg.sv
// Shared types and constants for the GPS/TSC 1PPS phase-frequency detector.
package pps_pfd_ctrl_pkg;

  localparam int unsigned CLKS_PER_SEC   = 100_000_000;
  localparam int unsigned CLKS_PER_SEC_2 = CLKS_PER_SEC / 2;

  // One-hot encoding; the four upper codes are spares that decode back to IDLE.
  typedef enum logic [10:0] {
    PFD_IDLE     = 11'b000_0000_0001,
    PFD_SYNC     = 11'b000_0000_0010,
    PFD_WAIT_TS  = 11'b000_0000_0100,
    PFD_WAIT_GPS = 11'b000_0000_1000,
    PFD_LEAD     = 11'b000_0001_0000,
    PFD_LAG      = 11'b000_0010_0000,
    PFD_TRIG     = 11'b000_0100_0000,
    PFD_SPARE7   = 11'b000_1000_0000,
    PFD_SPARE8   = 11'b001_0000_0000,
    PFD_SPARE9   = 11'b010_0000_0000,
    PFD_SPARE10  = 11'b100_0000_0000
  } pfd_t;

endpackage

// File: rtl/pps_pfd_ctrl.sv
// GPS vs TSC 1PPS phase/frequency detector: aligns the TSC, measures phase error each second.
// Optional macro PFD_AUTO_RESYNC_EN: out-of-range phase or a timeout forces a TSC realign.
module pps_pfd_ctrl
  import pps_pfd_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = pps_pfd_ctrl_pkg::CLKS_PER_SEC,
  parameter int unsigned MAX_DIFF     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gps_1pps_d,
  input  logic        tsc_1pps_d,
  input  logic        gps_3dfix_d,
  input  logic        pfd_resync,
  output logic        tsc_sync,
  output logic        pll_trig,
  output logic        pfd_status,
  output logic [31:0] pdiff_1pps,
  output logic [31:0] fdiff_1pps
);

  localparam logic [31:0] TIMEOUT  = 32'(CLKS_PER_SEC / 2);
  localparam logic [31:0] DIFF_LIM = 32'(MAX_DIFF);
`ifdef PFD_AUTO_RESYNC_EN
  localparam bit AUTO_RESYNC = 1'b1;
`else
  localparam bit AUTO_RESYNC = 1'b0;
`endif

  pfd_t        state_q, state_d;
  logic [31:0] diff_cnt_q, diff_cnt_d;
  logic        first_meas_q, first_meas_d;
  logic        tsc_sync_q, tsc_sync_d;
  logic        pll_trig_q, pll_trig_d;
  logic        pfd_status_q, pfd_status_d;
  logic [31:0] pdiff_q, pdiff_d;
  logic [31:0] fdiff_q, fdiff_d;

  logic        meas_done;
  logic [31:0] meas_val;
  logic [31:0] meas_mag;
  logic        status_clr;

  // FSM: the TRIG state's measurement work is done on the closing edge, so TRIG is the pll_trig cycle.
  always_comb begin
    state_d    = state_q;
    meas_done  = 1'b0;
    meas_val   = '0;
    meas_mag   = '0;
    status_clr = 1'b0;
    if (state_q != PFD_IDLE && !gps_3dfix_d) begin
      state_d    = PFD_IDLE;
      status_clr = 1'b1;
    end else if (pfd_resync && gps_3dfix_d) begin
      state_d    = PFD_SYNC;
      status_clr = 1'b1;
    end else begin
      unique case (state_q)
        PFD_IDLE:     if (gps_3dfix_d) state_d = PFD_SYNC;
        PFD_SYNC:     if (gps_1pps_d) state_d = PFD_WAIT_TS;
        PFD_WAIT_TS:  if (gps_1pps_d) state_d = PFD_WAIT_GPS;
        PFD_WAIT_GPS: begin
          if (tsc_1pps_d && gps_1pps_d) begin
            state_d   = PFD_TRIG;
            meas_done = 1'b1;
          end else if (tsc_1pps_d) begin
            state_d = PFD_LEAD;
          end else if (gps_1pps_d) begin
            state_d = PFD_LAG;
          end
        end
        PFD_LEAD: begin
          if (gps_1pps_d) begin
            state_d   = PFD_TRIG;
            meas_done = 1'b1;
            meas_val  = diff_cnt_q;
            meas_mag  = diff_cnt_q;
          end else if (diff_cnt_q >= TIMEOUT) begin
            state_d    = AUTO_RESYNC ? PFD_SYNC : PFD_WAIT_GPS;
            status_clr = 1'b1;
          end
        end
        PFD_LAG: begin
          if (tsc_1pps_d) begin
            state_d   = PFD_TRIG;
            meas_done = 1'b1;
            meas_val  = 32'd0 - diff_cnt_q;
            meas_mag  = diff_cnt_q;
          end else if (diff_cnt_q >= TIMEOUT) begin
            state_d    = AUTO_RESYNC ? PFD_SYNC : PFD_WAIT_GPS;
            status_clr = 1'b1;
          end
        end
        PFD_TRIG:     state_d = (AUTO_RESYNC && !pfd_status_q) ? PFD_SYNC : PFD_WAIT_GPS;
        default:      state_d = PFD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PFD_IDLE;
    else        state_q <= state_d;
  end

  // Phase counter: starts at 1 on the opening pulse so the count equals the pulse separation.
  always_comb begin
    diff_cnt_d = '0;
    if (state_d == PFD_LEAD || state_d == PFD_LAG)
      diff_cnt_d = (state_q == PFD_WAIT_GPS) ? 32'd1 : diff_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) diff_cnt_q <= '0;
    else        diff_cnt_q <= diff_cnt_d;
  end

  always_comb begin
    tsc_sync_d   = (state_d == PFD_SYNC);
    pll_trig_d   = meas_done;
    first_meas_d = (state_q == PFD_SYNC) ? 1'b1 : (meas_done ? 1'b0 : first_meas_q);
    pdiff_d      = meas_done ? meas_val : pdiff_q;
    fdiff_d      = fdiff_q;
    pfd_status_d = status_clr ? 1'b0 : pfd_status_q;
    if (meas_done) begin
      fdiff_d      = first_meas_q ? 32'd0 : meas_val - pdiff_q;
      pfd_status_d = (meas_mag <= DIFF_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_meas_q <= 1'b1;
      tsc_sync_q   <= 1'b0;
      pll_trig_q   <= 1'b0;
      pfd_status_q <= 1'b0;
      pdiff_q      <= '0;
      fdiff_q      <= '0;
    end else begin
      first_meas_q <= first_meas_d;
      tsc_sync_q   <= tsc_sync_d;
      pll_trig_q   <= pll_trig_d;
      pfd_status_q <= pfd_status_d;
      pdiff_q      <= pdiff_d;
      fdiff_q      <= fdiff_d;
    end
  end

  assign tsc_sync   = tsc_sync_q;
  assign pll_trig   = pll_trig_q;
  assign pfd_status = pfd_status_q;
  assign pdiff_1pps = pdiff_q;
  assign fdiff_1pps = fdiff_q;

endmodule

// File: tb/tb_pps_pfd_ctrl.sv
// Directed bench for pps_pfd_ctrl with a shortened second (4000 clk) so timeouts stay small.
module tb_pps_pfd_ctrl;

  localparam logic [10:0] S_IDLE     = 11'b000_0000_0001;
  localparam logic [10:0] S_SYNC     = 11'b000_0000_0010;
  localparam logic [10:0] S_WAIT_GPS = 11'b000_0000_1000;
  localparam logic [10:0] S_LEAD     = 11'b000_0001_0000;
  localparam logic [10:0] S_LAG      = 11'b000_0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gps_1pps_d = 1'b0;
  logic        tsc_1pps_d = 1'b0;
  logic        gps_3dfix_d = 1'b0;
  logic        pfd_resync = 1'b0;
  logic        tsc_sync;
  logic        pll_trig;
  logic        pfd_status;
  logic [31:0] pdiff_1pps;
  logic [31:0] fdiff_1pps;

  int errors = 0;
  int checks = 0;

  pps_pfd_ctrl #(.CLKS_PER_SEC(4000), .MAX_DIFF(1000)) dut (
    .clk(clk), .rst_n(rst_n), .gps_1pps_d(gps_1pps_d), .tsc_1pps_d(tsc_1pps_d),
    .gps_3dfix_d(gps_3dfix_d), .pfd_resync(pfd_resync), .tsc_sync(tsc_sync),
    .pll_trig(pll_trig), .pfd_status(pfd_status), .pdiff_1pps(pdiff_1pps),
    .fdiff_1pps(fdiff_1pps)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic g, input logic t);
    gps_1pps_d = g;
    tsc_1pps_d = t;
    tick(1);
    gps_1pps_d = 1'b0;
    tsc_1pps_d = 1'b0;
  endtask

  // Opening pulse, n-1 idle cycles, then closing pulse n cycles after the opening one.
  task automatic measure(input logic tsc_first, input int n);
    pulse(!tsc_first, tsc_first);
    tick(n - 1);
    pulse(tsc_first, !tsc_first);
    $display("meas tsc_first=%0b sep=%0d pll_trig=%0b pdiff=%0d fdiff=%0d status=%0b",
             tsc_first, n, pll_trig, $signed(pdiff_1pps), $signed(fdiff_1pps), pfd_status);
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (tsc_sync !== 1'b0) begin errors++; $display("FAIL reset_tsc_sync got %0b want 0", tsc_sync); end
    checks++; if (pll_trig !== 1'b0) begin errors++; $display("FAIL reset_pll_trig got %0b want 0", pll_trig); end
    checks++; if (pfd_status !== 1'b0) begin errors++; $display("FAIL reset_status got %0b want 0", pfd_status); end
    checks++; if (pdiff_1pps !== 32'd0) begin errors++; $display("FAIL reset_pdiff got %0h want 0", pdiff_1pps); end
    checks++; if (fdiff_1pps !== 32'd0) begin errors++; $display("FAIL reset_fdiff got %0h want 0", fdiff_1pps); end
    rst_n = 1'b1;
    tick(2);
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL reset_state got %0h want %0h", dut.state_q, S_IDLE); end
  endtask

  task automatic test_sync();
    gps_3dfix_d = 1'b1;
    tick(1);
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL sync_enter got %0b want 1", tsc_sync); end
    pfd_resync = 1'b1;
    tick(1);
    pfd_resync = 1'b0;
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL sync_resync_noeffect got %0b want 1", tsc_sync); end
    tick(20);
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL sync_hold got %0b want 1", tsc_sync); end
    pulse(1'b1, 1'b0);
    checks++; if (tsc_sync !== 1'b0) begin errors++; $display("FAIL sync_drop got %0b want 0", tsc_sync); end
    tick(50);
    pulse(1'b1, 1'b1);
    checks++; if (pll_trig !== 1'b0) begin errors++; $display("FAIL sync_discard_trig got %0b want 0", pll_trig); end
    tick(50);
    pulse(1'b1, 1'b1);
    $display("meas aligned pll_trig=%0b pdiff=%0d", pll_trig, $signed(pdiff_1pps));
    checks++; if (pll_trig !== 1'b1) begin errors++; $display("FAIL aligned_trig got %0b want 1", pll_trig); end
    checks++; if (pdiff_1pps !== 32'd0) begin errors++; $display("FAIL aligned_pdiff got %0h want 0", pdiff_1pps); end
    checks++; if (pfd_status !== 1'b1) begin errors++; $display("FAIL aligned_status got %0b want 1", pfd_status); end
    tick(1);
    checks++; if (pll_trig !== 1'b0) begin errors++; $display("FAIL aligned_trig_width got %0b want 0", pll_trig); end
  endtask

  task automatic test_lead();
    int exp_v;
    pfd_resync = 1'b1;
    tick(1);
    pfd_resync = 1'b0;
    checks++; if (pfd_status !== 1'b0) begin errors++; $display("FAIL resync_status got %0b want 0", pfd_status); end
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL resync_tsc_sync got %0b want 1", tsc_sync); end
    pulse(1'b1, 1'b0);
    tick(10);
    pulse(1'b1, 1'b1);
    tick(10);
    measure(1'b1, 250);
    checks++; if (pll_trig !== 1'b1) begin errors++; $display("FAIL lead250_trig got %0b want 1", pll_trig); end
    checks++; if (pdiff_1pps !== 32'd250) begin errors++; $display("FAIL lead250_pdiff got %0d want 250", pdiff_1pps); end
    checks++; if (fdiff_1pps !== 32'd0) begin errors++; $display("FAIL lead250_fdiff got %0d want 0", fdiff_1pps); end
    checks++; if (pfd_status !== 1'b1) begin errors++; $display("FAIL lead250_status got %0b want 1", pfd_status); end
    tick(5);
    checks++; if (pdiff_1pps !== 32'd250) begin errors++; $display("FAIL lead250_hold got %0d want 250", pdiff_1pps); end
    measure(1'b1, 260);
    checks++; if (pdiff_1pps !== 32'd260) begin errors++; $display("FAIL lead260_pdiff got %0d want 260", pdiff_1pps); end
    checks++; if (fdiff_1pps !== 32'd10) begin errors++; $display("FAIL lead260_fdiff got %0d want 10", fdiff_1pps); end
    tick(5);
    measure(1'b1, 1000);
    exp_v = 740;
    checks++; if (fdiff_1pps !== 32'(exp_v)) begin errors++; $display("FAIL lead1000_fdiff got %0d want %0d", fdiff_1pps, exp_v); end
    checks++; if (pfd_status !== 1'b1) begin errors++; $display("FAIL lead1000_status got %0b want 1", pfd_status); end
  endtask

  task automatic test_lag();
    int exp_p;
    int exp_f;
    tick(5);
    measure(1'b0, 1500);
    exp_p = -1500;
    exp_f = -2500;
    checks++; if (pll_trig !== 1'b1) begin errors++; $display("FAIL lag_trig got %0b want 1", pll_trig); end
    checks++; if (pdiff_1pps !== 32'(exp_p)) begin errors++; $display("FAIL lag_pdiff got %0h want %0h", pdiff_1pps, 32'(exp_p)); end
    checks++; if (fdiff_1pps !== 32'(exp_f)) begin errors++; $display("FAIL lag_fdiff got %0h want %0h", fdiff_1pps, 32'(exp_f)); end
    checks++; if (pfd_status !== 1'b0) begin errors++; $display("FAIL lag_status got %0b want 0", pfd_status); end
    tick(1);
`ifdef PFD_AUTO_RESYNC_EN
    checks++; if (dut.state_q !== S_SYNC) begin errors++; $display("FAIL lag_auto_state got %0h want %0h", dut.state_q, S_SYNC); end
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL lag_auto_tsc_sync got %0b want 1", tsc_sync); end
    pulse(1'b1, 1'b0);
    tick(5);
    pulse(1'b1, 1'b0);
`else
    checks++; if (dut.state_q !== S_WAIT_GPS) begin errors++; $display("FAIL lag_state got %0h want %0h", dut.state_q, S_WAIT_GPS); end
    checks++; if (tsc_sync !== 1'b0) begin errors++; $display("FAIL lag_tsc_sync got %0b want 0", tsc_sync); end
`endif
  endtask

  task automatic test_timeout();
    int trig_seen;
    logic [10:0] exp_s;
    tick(5);
    pulse(1'b1, 1'b1);
    checks++; if (pfd_status !== 1'b1) begin errors++; $display("FAIL pre_timeout_status got %0b want 1", pfd_status); end
    tick(5);
    pulse(1'b0, 1'b1);
    trig_seen = 0;
    for (int i = 0; i < 1999; i++) begin
      tick(1);
      if (pll_trig) trig_seen++;
    end
    checks++; if (dut.state_q !== S_LEAD) begin errors++; $display("FAIL timeout_early_state got %0h want %0h", dut.state_q, S_LEAD); end
    checks++; if (pfd_status !== 1'b1) begin errors++; $display("FAIL timeout_early_status got %0b want 1", pfd_status); end
    tick(1);
    if (pll_trig) trig_seen++;
    $display("timeout after 2000 cycles status=%0b trig_seen=%0d", pfd_status, trig_seen);
`ifdef PFD_AUTO_RESYNC_EN
    exp_s = S_SYNC;
`else
    exp_s = S_WAIT_GPS;
`endif
    checks++; if (pfd_status !== 1'b0) begin errors++; $display("FAIL timeout_status got %0b want 0", pfd_status); end
    checks++; if (trig_seen !== 0) begin errors++; $display("FAIL timeout_trig got %0d pulses want 0", trig_seen); end
    checks++; if (dut.state_q !== exp_s) begin errors++; $display("FAIL timeout_state got %0h want %0h", dut.state_q, exp_s); end
  endtask

  task automatic test_fix_drop();
    logic [31:0] exp_f;
`ifdef PFD_AUTO_RESYNC_EN
    pulse(1'b1, 1'b0);
    tick(5);
    pulse(1'b1, 1'b0);
    exp_f = 32'd0;
`else
    exp_f = 32'd100;
`endif
    tick(5);
    measure(1'b1, 100);
    checks++; if (pdiff_1pps !== 32'd100) begin errors++; $display("FAIL lead100_pdiff got %0d want 100", pdiff_1pps); end
    checks++; if (fdiff_1pps !== exp_f) begin errors++; $display("FAIL lead100_fdiff got %0d want %0d", fdiff_1pps, exp_f); end
    tick(5);
    pulse(1'b0, 1'b1);
    tick(10);
    gps_3dfix_d = 1'b0;
    tick(1);
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL fixdrop_state got %0h want %0h", dut.state_q, S_IDLE); end
    checks++; if (tsc_sync !== 1'b0) begin errors++; $display("FAIL fixdrop_tsc_sync got %0b want 0", tsc_sync); end
    checks++; if (pfd_status !== 1'b0) begin errors++; $display("FAIL fixdrop_status got %0b want 0", pfd_status); end
    checks++; if (pdiff_1pps !== 32'd100) begin errors++; $display("FAIL fixdrop_pdiff got %0d want 100", pdiff_1pps); end
    checks++; if (fdiff_1pps !== exp_f) begin errors++; $display("FAIL fixdrop_fdiff got %0d want %0d", fdiff_1pps, exp_f); end
  endtask

  task automatic test_async_reset();
    gps_3dfix_d = 1'b1;
    tick(1);
    pulse(1'b1, 1'b0);
    tick(3);
    pulse(1'b1, 1'b0);
    tick(3);
    pulse(1'b1, 1'b0);
    tick(5);
    checks++; if (dut.state_q !== S_LAG) begin errors++; $display("FAIL prereset_state got %0h want %0h", dut.state_q, S_LAG); end
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted pdiff=%0d state=%0h", $signed(pdiff_1pps), dut.state_q);
    checks++; if (pdiff_1pps !== 32'd0) begin errors++; $display("FAIL areset_pdiff got %0h want 0", pdiff_1pps); end
    checks++; if (fdiff_1pps !== 32'd0) begin errors++; $display("FAIL areset_fdiff got %0h want 0", fdiff_1pps); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL areset_state got %0h want %0h", dut.state_q, S_IDLE); end
    checks++; if ({tsc_sync, pll_trig, pfd_status} !== 3'b000) begin errors++; $display("FAIL areset_flags got %0b want 000", {tsc_sync, pll_trig, pfd_status}); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++; if (tsc_sync !== 1'b1) begin errors++; $display("FAIL restart_sync got %0b want 1", tsc_sync); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_lead();
    test_lag();
    test_timeout();
    test_fix_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
